vga_timing_gen: RTL and testbench

//  Generates VGA raster timing: horizontal/vertical pixel counters, sync and blanking flags.

---
 rtl/vga_timing_pkg.sv | 19 +
 rtl/vga_axis_counter.sv | 50 +++++
 rtl/vga_timing_gen.sv | 75 +++++++
 tb/tb_vga_timing_gen.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Default 800x600@60 raster constants (40 MHz pixel clock) shared by the timing
// generator, the pixel pipeline and the delay stages.
package vga_timing_pkg;

   localparam int H_ACTIVE = 800;
   localparam int H_FP     = 40;
   localparam int H_SYNC   = 128;
   localparam int H_BP     = 88;
   localparam int V_ACTIVE = 600;
   localparam int V_FP     = 1;
   localparam int V_SYNC   = 4;
   localparam int V_BP     = 23;
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int CNT_W    = 11;

   typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with terminal count, plus
// registered sync/blank flags derived from the next count value.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int CNT_W  = vga_timing_pkg::CNT_W,
   parameter int ACTIVE = vga_timing_pkg::H_ACTIVE,
   parameter int FP     = vga_timing_pkg::H_FP,
   parameter int SYNC   = vga_timing_pkg::H_SYNC,
   parameter int BP     = vga_timing_pkg::H_BP,
   parameter bit POL    = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count,
   output logic             tc,
   output logic             sync,
   output logic             blnk
);

   localparam int TOTAL = ACTIVE + FP + SYNC + BP;
   localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
   localparam logic [CNT_W-1:0] ACT_END    = CNT_W'(ACTIVE);
   localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(ACTIVE + FP);
   localparam logic [CNT_W-1:0] SYNC_END   = CNT_W'(ACTIVE + FP + SYNC);

   logic [CNT_W-1:0] nxt;

   assign tc = (count == LAST);

   // wrap by compare only; natural overflow is never relied upon
   always_comb begin
      nxt = count + CNT_W'(1);
      if (tc) nxt = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
         sync  <= ~POL;
         blnk  <= 1'b0;
      end else if (inc) begin
         count <= nxt;
         blnk  <= (nxt >= ACT_END);
         sync  <= ((nxt >= SYNC_START) && (nxt < SYNC_END)) ? POL : ~POL;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: h/v counters, sync, blank and frame_start.
// Optional macro VGA_TIMING_FRAME_CNT_EN adds a 16-bit frame counter output.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int CNT_W    = vga_timing_pkg::CNT_W,
   parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
   parameter int H_FP     = vga_timing_pkg::H_FP,
   parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
   parameter int H_BP     = vga_timing_pkg::H_BP,
   parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
   parameter int V_FP     = vga_timing_pkg::V_FP,
   parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
   parameter int V_BP     = vga_timing_pkg::V_BP,
   parameter bit HS_POL   = 1'b1,
   parameter bit VS_POL   = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ce,
   output logic [CNT_W-1:0] hcount,
   output logic [CNT_W-1:0] vcount,
   output logic             hsync,
   output logic             vsync,
   output logic             hblnk,
   output logic             vblnk,
`ifdef VGA_TIMING_FRAME_CNT_EN
   output logic [15:0]      frame_cnt,
`endif
   output logic             frame_start
);

   localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

   if (CNT_W < 1 || CNT_W > 30 || H_TOT >= (1 << CNT_W) || V_TOT >= (1 << CNT_W) ||
       H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
       V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_param_err
      $error("vga_timing_gen: illegal CNT_W or zero-length timing parameter");
   end

   logic h_tc;
   logic v_tc;
   logic v_inc;

   assign v_inc = ce & h_tc;

   vga_axis_counter #(
      .CNT_W(CNT_W), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL)
   ) u_h (
      .clk(clk), .rst(rst), .inc(ce),
      .count(hcount), .tc(h_tc), .sync(hsync), .blnk(hblnk)
   );

   vga_axis_counter #(
      .CNT_W(CNT_W), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL)
   ) u_v (
      .clk(clk), .rst(rst), .inc(v_inc),
      .count(vcount), .tc(v_tc), .sync(vsync), .blnk(vblnk)
   );

   // pulse lands in the same cycle the counters read (0,0)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) frame_start <= 1'b0;
      else     frame_start <= v_inc & v_tc;
   end

`ifdef VGA_TIMING_FRAME_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)              frame_cnt <= '0;
      else if (v_inc & v_tc) frame_cnt <= frame_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a tiny 8x6 raster, with a second
// instance using active-low syncs.
module tb_vga_timing_gen;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          ce;
   logic [CW-1:0] hc, vc, hc_n, vc_n;
   logic          hs, vs, hb, vb, fs;
   logic          hs_n, vs_n, hb_n, vb_n, fs_n;
`ifdef VGA_TIMING_FRAME_CNT_EN
   logic [15:0]   fcnt, fcnt_n;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   vga_timing_gen #(
      .CNT_W(CW), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1)
   ) dut (
      .clk(clk), .rst(rst), .ce(ce), .hcount(hc), .vcount(vc),
      .hsync(hs), .vsync(vs), .hblnk(hb), .vblnk(vb),
`ifdef VGA_TIMING_FRAME_CNT_EN
      .frame_cnt(fcnt),
`endif
      .frame_start(fs)
   );

   vga_timing_gen #(
      .CNT_W(CW), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0)
   ) dut_n (
      .clk(clk), .rst(rst), .ce(ce), .hcount(hc_n), .vcount(vc_n),
      .hsync(hs_n), .vsync(vs_n), .hblnk(hb_n), .vblnk(vb_n),
`ifdef VGA_TIMING_FRAME_CNT_EN
      .frame_cnt(fcnt_n),
`endif
      .frame_start(fs_n)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset(input string tag);
      check({tag, " hcount"}, 32'(hc), 0);
      check({tag, " vcount"}, 32'(vc), 0);
      check({tag, " hblnk"}, 32'(hb), 0);
      check({tag, " vblnk"}, 32'(vb), 0);
      check({tag, " frame_start"}, 32'(fs), 0);
      check({tag, " hsync"}, 32'(hs), 0);
      check({tag, " vsync"}, 32'(vs), 0);
      check({tag, " hsync_n"}, 32'(hs_n), 1);
      check({tag, " vsync_n"}, 32'(vs_n), 1);
      check({tag, " fs_n"}, 32'(fs_n), 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
      check({tag, " frame_cnt"}, 32'(fcnt), 0);
`endif
   endtask

   initial begin
      rst = 1'b1;
      ce  = 1'b0;
      #12;
      check_reset("rst0");
      rst = 1'b0;
      ce  = 1'b1;

      // three full frames with ce held high
      for (int k = 1; k <= 144; k++) begin
         int h, v;
         bit hsa, vsa;
         step();
         h   = k % 8;
         v   = (k / 8) % 6;
         hsa = (h == 5) || (h == 6);
         vsa = (v == 4);
         check($sformatf("run%0d hcount", k), 32'(hc), h);
         check($sformatf("run%0d vcount", k), 32'(vc), v);
         check($sformatf("run%0d hblnk", k), 32'(hb), (h >= 4) ? 1 : 0);
         check($sformatf("run%0d vblnk", k), 32'(vb), (v >= 3) ? 1 : 0);
         check($sformatf("run%0d hsync", k), 32'(hs), hsa ? 1 : 0);
         check($sformatf("run%0d vsync", k), 32'(vs), vsa ? 1 : 0);
         check($sformatf("run%0d frame_start", k), 32'(fs), (k % 48 == 0) ? 1 : 0);
         check($sformatf("run%0d hsync_n", k), 32'(hs_n), hsa ? 0 : 1);
         check($sformatf("run%0d vsync_n", k), 32'(vs_n), vsa ? 0 : 1);
         check($sformatf("run%0d hcount_n", k), 32'(hc_n), h);
         check($sformatf("run%0d vcount_n", k), 32'(vc_n), v);
         check($sformatf("run%0d hblnk_n", k), 32'(hb_n), (h >= 4) ? 1 : 0);
         check($sformatf("run%0d vblnk_n", k), 32'(vb_n), (v >= 3) ? 1 : 0);
         check($sformatf("run%0d fs_n", k), 32'(fs_n), (k % 48 == 0) ? 1 : 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
         check($sformatf("run%0d frame_cnt", k), 32'(fcnt), k / 48);
`endif
      end

      // ce gating: 1,0,1,0
      rst = 1'b1;
      #2;
      check_reset("rst1");
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         ce = (i % 2 == 0);
         step();
         check($sformatf("ce%0d hcount", i), 32'(hc), (i / 2) + 1);
         check($sformatf("ce%0d vcount", i), 32'(vc), 0);
         check($sformatf("ce%0d frame_start", i), 32'(fs), 0);
      end

      // async reset mid-cycle at (6,2)
      rst = 1'b1;
      #2;
      rst = 1'b0;
      ce  = 1'b1;
      repeat (22) step();
      check("pre_rst hcount", 32'(hc), 6);
      check("pre_rst vcount", 32'(vc), 2);
      #2;
      rst = 1'b1;
      #1;
      check_reset("async");
      #2;
      rst = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         step();
         check($sformatf("post%0d hcount", k), 32'(hc), k % 8);
         check($sformatf("post%0d vcount", k), 32'(vc), k / 8);
         check($sformatf("post%0d frame_start", k), 32'(fs), 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
